memory: RTL and testbench

//  Single-port synchronous word memory: 262,144 words of 24 bits, one word per 512x512 RGB pixel.

---
 rtl/memory.sv | 70 +++++++
 tb/tb_memory.sv | 115 +++++++++++
 2 files changed

// File: rtl/memory.sv
// Single-port 512x512 RGB pixel store: synchronous write, registered read,
// and a one-cycle acknowledge for every accepted read or write command.
module memory #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 512 * 512,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Mem_CLK,
  input  logic                  Mem_RST,
  input  logic [1:0]            Mem_RW,
  input  logic [DATA_WIDTH-1:0] Mem_IDR,
  input  logic [ADDR_WIDTH-1:0] Mem_ADDR,
  output logic [DATA_WIDTH-1:0] Mem_ODR,
  output logic                  Mem_DRDY
);

  localparam int IDX_WIDTH = $clog2(DEPTH);

  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  logic [DATA_WIDTH-1:0] mem_array [0:DEPTH-1];

  logic                  is_write;
  logic                  is_read;
  logic                  in_range;
  logic [IDX_WIDTH-1:0]  word_idx;
  logic [DATA_WIDTH-1:0] odr_reg;
  logic [DATA_WIDTH-1:0] odr_next;
  logic                  drdy_reg;
  logic                  drdy_next;

  // Full-width compare so addresses at or above DEPTH never wrap onto low words.
  assign in_range = (Mem_ADDR < ADDR_WIDTH'(DEPTH));
  assign word_idx = Mem_ADDR[IDX_WIDTH-1:0];
  assign is_write = (Mem_RW == CMD_WRITE);
  assign is_read  = (Mem_RW == CMD_READ);

  // Write port kept free of output-register logic so it maps onto block RAM.
  always_ff @(posedge Mem_CLK) begin
    if (!Mem_RST && is_write && in_range) begin
      mem_array[word_idx] <= Mem_IDR;
    end
  end

  always_comb begin
    odr_next  = odr_reg;
    drdy_next = 1'b0;
    if (is_write) begin
      drdy_next = 1'b1;
    end else if (is_read) begin
      drdy_next = 1'b1;
      odr_next  = in_range ? mem_array[word_idx] : '0;
    end
  end

  always_ff @(posedge Mem_CLK) begin
    if (Mem_RST) begin
      odr_reg  <= '0;
      drdy_reg <= 1'b0;
    end else begin
      odr_reg  <= odr_next;
      drdy_reg <= drdy_next;
    end
  end

  assign Mem_ODR  = odr_reg;
  assign Mem_DRDY = drdy_reg;

endmodule

// File: tb/tb_memory.sv
// Directed bench for the pixel memory: reset, write/read, back-to-back,
// hold, address bounds and reset priority, each checked by immediate assertion.
module tb_memory;

  logic        Mem_CLK;
  logic        Mem_RST;
  logic [1:0]  Mem_RW;
  logic [23:0] Mem_IDR;
  logic [31:0] Mem_ADDR;
  logic [23:0] Mem_ODR;
  logic        Mem_DRDY;

  int checks;
  int failures;

  memory dut (
    .Mem_CLK  (Mem_CLK),
    .Mem_RST  (Mem_RST),
    .Mem_RW   (Mem_RW),
    .Mem_IDR  (Mem_IDR),
    .Mem_ADDR (Mem_ADDR),
    .Mem_ODR  (Mem_ODR),
    .Mem_DRDY (Mem_DRDY)
  );

  initial Mem_CLK = 1'b0;
  always #5 Mem_CLK = ~Mem_CLK;

  // Apply one command across one rising edge, then settle past the edge.
  task automatic step(input logic rst, input logic [1:0] rw,
                      input logic [31:0] addr, input logic [23:0] data);
    Mem_RST  = rst;
    Mem_RW   = rw;
    Mem_ADDR = addr;
    Mem_IDR  = data;
    @(posedge Mem_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] exp_odr, input logic exp_drdy);
    checks++;
    assert (Mem_ODR === exp_odr) else begin
      failures++;
      $error("FAIL %s odr observed=%06h expected=%06h", tag, Mem_ODR, exp_odr);
    end
    checks++;
    assert (Mem_DRDY === exp_drdy) else begin
      failures++;
      $error("FAIL %s drdy observed=%0b expected=%0b", tag, Mem_DRDY, exp_drdy);
    end
    $display("step %-14s odr=%06h drdy=%0b", tag, Mem_ODR, Mem_DRDY);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Mem_RST  = 1'b1;
    Mem_RW   = 2'b00;
    Mem_ADDR = '0;
    Mem_IDR  = '0;

    // Reset
    step(1'b1, 2'b00, 32'h0, 24'h0);          check("reset", 24'h000000, 1'b0);
    step(1'b0, 2'b00, 32'h0, 24'h0);          check("idle_after_rst", 24'h000000, 1'b0);
    step(1'b0, 2'b00, 32'h0, 24'h0);          check("idle_after_rst2", 24'h000000, 1'b0);

    // Write two words, idle, read them back
    step(1'b0, 2'b01, 32'h0, 24'hAABBCC);     check("wr0", 24'h000000, 1'b1);
    step(1'b0, 2'b01, 32'h1, 24'h112233);     check("wr1", 24'h000000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00, 32'h0, 24'h0);        check("idle5", 24'h000000, 1'b0);
    end
    step(1'b0, 2'b10, 32'h0, 24'h0);          check("rd0", 24'hAABBCC, 1'b1);
    step(1'b0, 2'b10, 32'h1, 24'h0);          check("rd1", 24'h112233, 1'b1);

    // Back-to-back write then read of same address
    step(1'b0, 2'b01, 32'h10, 24'h123456);    check("b2b_wr", 24'h112233, 1'b1);
    step(1'b0, 2'b10, 32'h10, 24'h0);         check("b2b_rd", 24'h123456, 1'b1);

    // Hold through idle cycles
    step(1'b0, 2'b10, 32'h1, 24'h0);          check("hold_rd", 24'h112233, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 32'h0, 24'h0);        check("hold_idle", 24'h112233, 1'b0);
    end

    // Last valid address
    step(1'b0, 2'b01, 32'h3FFFF, 24'h0F0F0F); check("wr_top", 24'h112233, 1'b1);
    step(1'b0, 2'b10, 32'h3FFFF, 24'h0);      check("rd_top", 24'h0F0F0F, 1'b1);

    // Out of range: discarded write, zero read, no aliasing onto word 0
    step(1'b0, 2'b01, 32'h40000, 24'hFFFFFF); check("wr_oor", 24'h0F0F0F, 1'b1);
    step(1'b0, 2'b10, 32'h40000, 24'h0);      check("rd_oor", 24'h000000, 1'b1);
    step(1'b0, 2'b10, 32'h0, 24'h0);          check("rd0_noalias", 24'hAABBCC, 1'b1);
    step(1'b0, 2'b01, 32'h80000001, 24'hDEAD01); check("wr_oor_hi", 24'hAABBCC, 1'b1);
    step(1'b0, 2'b10, 32'h1, 24'h0);          check("rd1_noalias", 24'h112233, 1'b1);

    // Reserved command behaves as idle
    step(1'b0, 2'b11, 32'h0, 24'h777777);     check("reserved", 24'h112233, 1'b0);
    step(1'b0, 2'b10, 32'h0, 24'h0);          check("rd0_after_res", 24'hAABBCC, 1'b1);

    // Reset priority: write sampled with reset must be dropped
    step(1'b0, 2'b01, 32'h2, 24'h555555);     check("wr2_seed", 24'hAABBCC, 1'b1);
    step(1'b1, 2'b01, 32'h2, 24'hABCDEF);     check("rst_wr", 24'h000000, 1'b0);
    step(1'b0, 2'b00, 32'h0, 24'h0);          check("post_rst_idle", 24'h000000, 1'b0);
    step(1'b0, 2'b10, 32'h2, 24'h0);          check("rd2_after_rst", 24'h555555, 1'b1);

    // Reset drops a read in the same cycle
    step(1'b1, 2'b10, 32'h0, 24'h0);          check("rst_rd", 24'h000000, 1'b0);
    step(1'b0, 2'b00, 32'h0, 24'h0);          check("post_rst_rd", 24'h000000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
